// File: rtl/hazard_pkg.sv
// Shared types for the hazard tracker: pipeline slot record, bubble value, stall reasons.
// HAZARD_ZERO_REG_EN makes register 0 a hardwired zero that never matches or writes.
package hazard_pkg;

  localparam int HZ_REG_W = 3;

`ifdef HAZARD_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef struct packed {
    logic [HZ_REG_W-1:0] rd;
    logic                wr;
    logic                ld;
  } slot_t;

  localparam slot_t BUBBLE = '{rd: '0, wr: 1'b0, ld: 1'b0};

  typedef enum logic [1:0] {
    SR_NONE,
    SR_LOAD_USE,
    SR_BR_EX,
    SR_BR_LDMEM
  } stall_reason_e;

  function automatic logic rd_writable(input logic [HZ_REG_W-1:0] r);
    return !ZERO_REG || (r != '0);
  endfunction

  function automatic logic slot_match(input slot_t s, input logic [HZ_REG_W-1:0] r);
    return s.wr && (s.rd == r) && rd_writable(r);
  endfunction

endpackage

// File: rtl/hazard_stall_cnt.sv
// Saturating up-counter with enable; counts stall cycles for performance monitoring.
// Holds at all-ones instead of wrapping.
module hazard_stall_cnt #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_tracker.sv
// Tracks EX/MEM/WB destination registers and raises stall/flush for hazards forwarding cannot cover.
// Optional HAZARD_ZERO_REG_EN: register 0 is hardwired zero (never written, never matched).
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int REG_W       = HZ_REG_W,  // must equal the package slot width
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   id_valid,
  input  logic [REG_W-1:0]       id_rs1,
  input  logic [REG_W-1:0]       id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_is_load,
  input  logic                   id_is_branch,
  input  logic                   id_branch_taken,
  output logic [REG_W-1:0]       rdEX,
  output logic [REG_W-1:0]       rdMEM,
  output logic [REG_W-1:0]       rdWB,
  output logic                   wrEX,
  output logic                   wrMEM,
  output logic                   wrWB,
  output logic                   stall,
  output logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_count
);

  slot_t            ex_q, ex_d, mem_q, mem_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic             wb_wr_q, wb_wr_d;
  stall_reason_e    reason;
  logic             ex_dep, mem_dep;

  always_comb begin
    ex_dep  = (id_use_rs1 && slot_match(ex_q, id_rs1)) ||
              (id_use_rs2 && slot_match(ex_q, id_rs2));
    mem_dep = (id_use_rs1 && slot_match(mem_q, id_rs1)) ||
              (id_use_rs2 && slot_match(mem_q, id_rs2));

    // Branches resolve in ID and can only take forwarded values from MEM.
    reason = SR_NONE;
    if (id_valid) begin
      if (ex_q.ld && ex_dep)                       reason = SR_LOAD_USE;
      else if (id_is_branch && ex_dep)             reason = SR_BR_EX;
      else if (id_is_branch && mem_q.ld && mem_dep) reason = SR_BR_LDMEM;
    end

    stall = (reason != SR_NONE);
    flush = id_valid && id_is_branch && id_branch_taken && !stall;

    ex_d = BUBBLE;
    if (id_valid && !stall) begin
      ex_d.rd = id_rd;
      ex_d.wr = id_regwrite && rd_writable(id_rd);
      ex_d.ld = id_is_load && ex_d.wr;
    end

    mem_d   = ex_q;
    wb_rd_d = mem_q.rd;
    wb_wr_d = mem_q.wr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_rd_q <= '0;
      wb_wr_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_rd_q <= wb_rd_d;
      wb_wr_q <= wb_wr_d;
    end
  end

  assign rdEX  = ex_q.rd;
  assign rdMEM = mem_q.rd;
  assign rdWB  = wb_rd_q;
  assign wrEX  = ex_q.wr;
  assign wrMEM = mem_q.wr;
  assign wrWB  = wb_wr_q;

  hazard_stall_cnt #(.W(STALL_CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (stall),
    .count   (stall_count)
  );

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Producer side of the forwarding path: tracks destination registers of in-flight instructions in EX, MEM and WB.
- Drives rdEX/rdMEM/rdWB, plus per-stage valid/write flags, to the Forward unit and the register file.
- Detects hazards that forwarding cannot cover (load-use, ID-stage branch operands) and issues stall/flush to IF/ID.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_W, 3, register index width (8 registers).
- STALL_CNT_W, 16, stall-cycle counter width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_W  ID source register 1.
- id_rs2  in  REG_W  ID source register 2.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_W  ID destination register.
- id_regwrite  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_is_branch  in  1  instruction is a branch, resolved in ID.
- id_branch_taken  in  1  ID branch comparison result (taken).
- rdEX, rdMEM, rdWB  out  REG_W each  destination register per stage.
- wrEX, wrMEM, wrWB  out  1 each  stage valid AND regwrite.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush  out  1  squash IF/ID contents (taken branch).
- stall_count  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, reset_n=0):
  - all rd* = 0, wr* = 0, internal load flags = 0, stall_count = 0.
  - stall and flush are combinational from state, so both read 0 during reset.
- State per slot (EX, MEM, WB): rd, wr, ld (ld is held for EX and MEM only).
- Each rising edge with reset_n=1:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (rd=0, wr=0, ld=0) if stall=1 or id_valid=0.
  - Otherwise EX <= {id_rd, id_regwrite, id_is_load & id_regwrite}.
- Match definitions:
  - mEX(r) = wrEX & (r==rdEX); mMEM(r) = wrMEM & (r==rdMEM).
  - A source operand is checked only when its id_use_rsN=1.
- stall (combinational, all terms gated by id_valid):
  - load-use: ldEX & mEX(rs).
  - branch on EX result: id_is_branch & mEX(rs). Branch forwarding comes only from MEM.
  - branch on MEM load: id_is_branch & ldMEM & mMEM(rs).
- Resulting latencies:
  - load followed by dependent ALU op: 1 stall cycle.
  - load followed by dependent branch: 2 stall cycles.
  - ALU op followed by dependent branch: 1 stall cycle.
- flush = id_valid & id_is_branch & id_branch_taken & ~stall. A branch that is stalled never flushes until its stall clears.
- Simultaneous stall and taken branch: stall wins; flush is asserted on the first non-stall cycle.
- No hazard on WB slot: the register file is write-first.
- stall_count increments on every cycle where stall=1. It saturates at all-ones, with no wrap.
- Reset asserted mid-stall: all slots clear immediately, stall drops in the same cycle, counter clears.

Optional Feature:
- Macro HAZARD_ZERO_REG_EN.
- When defined:
  - register 0 is hardwired zero; mEX/mMEM never match r==0.
  - id_rd==0 enters EX with wr=0, so wrEX/wrMEM/wrWB never assert for register 0.
- When undefined: register 0 is an ordinary register and participates in matching.

Decomposition:
- Package hazard_pkg holds:
  - REG_W default;
  - slot struct {rd, wr, ld};
  - BUBBLE constant;
  - stall-reason encoding (NONE, LOAD_USE, BR_EX, BR_LDMEM) for debug.
- One sub-module: hazard_stall_cnt, the saturating counter with enable.

Test Plan:
- Reset: assert reset_n=0 mid-stream -> all outputs 0 immediately; after release with id_valid=0 for 3 cycles -> wr* stay 0.
- ALU chain: issue rd=3 (regwrite), then rs1=3 non-branch -> stall=0; rdEX=3 then rdMEM=3 then rdWB=3 on consecutive cycles.
- Load-use: load rd=5, then add rs2=5 -> stall=1 exactly 1 cycle; EX bubble observed (wrEX=0); stall_count=1.
- Load-branch: load rd=2, then branch rs1=2 taken -> stall 2 cycles, then flush=1 for 1 cycle; stall_count=2.
- Taken branch, no hazard: branch rs1=1, rs2=4 with no matching slots -> flush=1 same cycle, stall=0.
- Zero register (HAZARD_ZERO_REG_EN defined): load rd=0, then add rs1=0 -> stall=0, wrEX=0; with macro undefined -> stall=1.
- Saturation: STALL_CNT_W=2, force 5 load-use stalls -> stall_count=3.
